// File: rtl/flag_register_stack.sv
// rtl/flag_register_stack.sv - parametrised status flag register with LIFO context stack
module flag_register_stack #(
    parameter int                 N_FLAGS     = 4,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [N_FLAGS-1:0] STICKY_MASK = '0,
    parameter int                 DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_FLAGS-1:0] flags_in,
    input  logic [N_FLAGS-1:0] update_mask,
    input  logic               clear_sticky,
    input  logic               load_en,
    input  logic [N_FLAGS-1:0] load_value,
    input  logic               push,
    input  logic               pop,
    input  logic               err_clear,
    output logic [N_FLAGS-1:0] flags,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               stack_ovf,
    output logic               stack_unf
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(STACK_DEPTH);

    logic [N_FLAGS-1:0] r_flags;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_ovf;
    logic               r_unf;
    logic [N_FLAGS-1:0] r_stack [STACK_DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push_only;
    logic               w_pop_only;
    logic               w_both;
    logic               w_valid_push;
    logic               w_valid_pop;
    logic               w_ovf_evt;
    logic               w_unf_evt;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_top_idx;
    logic [N_FLAGS-1:0] w_update;
    logic [N_FLAGS-1:0] w_flags_next;
    logic [DEPTH_W-1:0] w_depth_next;

    assign w_full       = (r_depth == MAX_DEPTH);
    assign w_empty      = (r_depth == '0);
    assign w_push_only  = push & ~pop;
    assign w_pop_only   = pop & ~push;
    assign w_both       = push & pop;
    assign w_valid_push = w_push_only & ~w_full;
    assign w_valid_pop  = w_pop_only & ~w_empty;
    // Simultaneous push and pop is illegal and raises both error flags.
    assign w_ovf_evt    = (w_push_only & w_full) | w_both;
    assign w_unf_evt    = (w_pop_only & w_empty) | w_both;
    assign w_wr_idx     = IDX_W'(r_depth);
    assign w_top_idx    = IDX_W'(r_depth - 1'b1);

    always_comb begin
        w_update = r_flags;
        for (int i = 0; i < N_FLAGS; i++) begin
            logic w_base;
            w_base = (clear_sticky & STICKY_MASK[i]) ? 1'b0 : r_flags[i];
            if (!update_mask[i]) begin
                w_update[i] = w_base;
            end else if (STICKY_MASK[i]) begin
                w_update[i] = w_base | flags_in[i];
            end else begin
                w_update[i] = flags_in[i];
            end
        end
    end

    always_comb begin
        w_flags_next = w_update;
        if (w_valid_pop) begin
            w_flags_next = r_stack[w_top_idx];
        end else if (load_en) begin
            w_flags_next = load_value;
        end
    end

    always_comb begin
        w_depth_next = r_depth;
        if (w_valid_push) begin
            w_depth_next = r_depth + 1'b1;
        end else if (w_valid_pop) begin
            w_depth_next = r_depth - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_flags <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_flags <= w_flags_next;
            r_depth <= w_depth_next;
            // A fresh error in the same cycle overrides err_clear.
            r_ovf   <= w_ovf_evt | (r_ovf & ~err_clear);
            r_unf   <= w_unf_evt | (r_unf & ~err_clear);
        end
    end

    // Contents are don't-care after reset, so only the write is gated.
    always_ff @(posedge clock) begin
        if (!reset && w_valid_push) begin
            r_stack[w_wr_idx] <= r_flags;
        end
    end

    assign flags       = r_flags;
    assign depth       = r_depth;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;

endmodule

// File: tb/tb_flag_register_stack.sv
// tb/tb_flag_register_stack.sv - directed self-checking bench for flag_register_stack
module tb_flag_register_stack;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] flags_in;
    logic [3:0] update_mask;
    logic       clear_sticky;
    logic       load_en;
    logic [3:0] load_value;
    logic       push;
    logic       pop;
    logic       err_clear;
    logic [3:0] flags;
    logic [2:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_ovf;
    logic       stack_unf;

    int n_checks = 0;
    int n_errors = 0;

    flag_register_stack #(
        .N_FLAGS    (4),
        .STACK_DEPTH(4),
        .STICKY_MASK(4'b1000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flags_in    (flags_in),
        .update_mask (update_mask),
        .clear_sticky(clear_sticky),
        .load_en     (load_en),
        .load_value  (load_value),
        .push        (push),
        .pop         (pop),
        .err_clear   (err_clear),
        .flags       (flags),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset        = 1'b0;
        flags_in     = 4'b0000;
        update_mask  = 4'b0000;
        clear_sticky = 1'b0;
        load_en      = 1'b0;
        load_value   = 4'b0000;
        push         = 1'b0;
        pop          = 1'b0;
        err_clear    = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_step(input logic [3:0] v, input logic p);
        load_en    = 1'b1;
        load_value = v;
        push       = p;
        step();
    endtask

    logic [3:0] fill_vals [4];

    initial begin
        fill_vals[0] = 4'b0001;
        fill_vals[1] = 4'b0010;
        fill_vals[2] = 4'b0100;
        fill_vals[3] = 4'b1000;

        idle();
        reset = 1'b1;
        step();
        check("rst_flags", flags, 4'b0000);
        check("rst_depth", depth, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_ovf", stack_ovf, 0);
        check("rst_unf", stack_unf, 0);

        update_mask = 4'b0111; flags_in = 4'b1111; step();
        check("upd1", flags, 4'b0111);
        update_mask = 4'b0101; flags_in = 4'b0000; step();
        check("upd2", flags, 4'b0010);

        update_mask = 4'b1000; flags_in = 4'b1000; step();
        check("sticky_set", flags, 4'b1010);
        update_mask = 4'b1000; flags_in = 4'b0000; step();
        check("sticky_hold", flags, 4'b1010);
        clear_sticky = 1'b1; step();
        check("sticky_clr", flags, 4'b0010);
        clear_sticky = 1'b1; update_mask = 4'b1000; flags_in = 4'b1000; step();
        check("sticky_clr_set", flags, 4'b1010);

        for (int i = 0; i < 4; i++) begin
            load_step(fill_vals[i], 1'b0);
            push = 1'b1; step();
            check("fill_depth", depth, i + 1);
        end
        check("fill_full", stack_full, 1);
        check("fill_empty", stack_empty, 0);

        load_step(4'b1111, 1'b1);
        check("ovf_flag", stack_ovf, 1);
        check("ovf_depth", depth, 4);
        check("ovf_update", flags, 4'b1111);

        for (int i = 3; i >= 0; i--) begin
            pop = 1'b1; update_mask = 4'b1111; flags_in = 4'b0101; step();
            check("drain_flags", flags, fill_vals[i]);
        end
        check("drain_empty", stack_empty, 1);
        check("drain_depth", depth, 0);
        check("drain_unf", stack_unf, 0);

        pop = 1'b1; load_en = 1'b1; load_value = 4'b1010; step();
        check("unf_flags", flags, 4'b1010);
        check("unf_flag", stack_unf, 1);
        check("unf_depth", depth, 0);
        err_clear = 1'b1; step();
        check("errclr_unf", stack_unf, 0);
        check("errclr_ovf", stack_ovf, 0);
        err_clear = 1'b1; pop = 1'b1; step();
        check("errclr_loses", stack_unf, 1);
        err_clear = 1'b1; step();

        load_step(4'b0011, 1'b0);
        load_step(4'b0000, 1'b1);
        check("prec_depth1", depth, 1);
        check("prec_flags0", flags, 4'b0000);
        pop = 1'b1; load_en = 1'b1; load_value = 4'b1111; step();
        check("prec_pop_wins", flags, 4'b0011);
        check("prec_depth0", depth, 0);

        load_step(4'b0101, 1'b0);
        push = 1'b1; load_en = 1'b1; load_value = 4'b0110; step();
        push = 1'b1; step();
        check("pp_depth_pre", depth, 2);
        push = 1'b1; pop = 1'b1; update_mask = 4'b0001; flags_in = 4'b0001; step();
        check("pp_depth", depth, 2);
        check("pp_ovf", stack_ovf, 1);
        check("pp_unf", stack_unf, 1);
        check("pp_flags", flags, 4'b0111);
        pop = 1'b1; step();
        check("pp_top", flags, 4'b0110);
        pop = 1'b1; step();
        check("pp_bottom", flags, 4'b0101);

        push = 1'b1; step();
        check("pre_rst_depth", depth, 1);
        reset = 1'b1; push = 1'b1; load_en = 1'b1; load_value = 4'b1111; step();
        check("rstpush_flags", flags, 4'b0000);
        check("rstpush_depth", depth, 0);
        check("rstpush_ovf", stack_ovf, 0);
        check("rstpush_unf", stack_unf, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flag_register_stack.md
Name: flag_register_stack

Overview:
- Parametrised flag register, successor to the fixed 4-flag ZCSO register.
- Holds N_FLAGS status flags with per-flag update enables supplied by the decoder, per-flag sticky (accumulating) mode, and a direct load path.
- Adds a LIFO save/restore stack so the flag context survives calls and interrupts.
- Sits between the ALU flag outputs and the branch/condition unit.

Parameters:
- N_FLAGS, 4, number of flags; bit0=Z, bit1=C, bit2=S, bit3=O at the default.
- STACK_DEPTH, 4, number of saved flag contexts; must be at least 1.
- STICKY_MASK, 4'b0000, N_FLAGS bits; a 1 makes that flag sticky, meaning it OR-accumulates instead of being overwritten.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth output.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flags_in  in  N_FLAGS  flag values from the ALU.
- update_mask  in  N_FLAGS  per-flag update enable from the decoder.
- clear_sticky  in  1  clears all sticky flags.
- load_en  in  1  overwrites all flags with load_value.
- load_value  in  N_FLAGS  value used by load_en.
- push  in  1  saves the current flags onto the stack.
- pop  in  1  restores flags from the stack top.
- err_clear  in  1  clears stack_ovf and stack_unf.
- flags  out  N_FLAGS  registered flag state.
- depth  out  DEPTH_W  number of stacked entries.
- stack_full  out  1  high when depth==STACK_DEPTH (combinational from depth).
- stack_empty  out  1  high when depth==0 (combinational from depth).
- stack_ovf  out  1  sticky: a push was attempted while full.
- stack_unf  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (synchronous, on the edge where reset=1):
  - flags=0, depth=0, stack_ovf=0, stack_unf=0.
  - Stack contents become don't-care; all other inputs are ignored that cycle.
- Latency: every effect is visible on the outputs 1 cycle after the qualifying edge. No combinational path from any input to flags.
- Flag next-state priority (highest first):
  1. Valid pop (pop=1, push=0, depth>0): flags <= stack[depth-1]. load_en, update_mask and clear_sticky are ignored.
  2. load_en=1: flags <= load_value. Update and clear are ignored.
  3. Update path, per bit i:
     - base = (clear_sticky & STICKY_MASK[i]) ? 0 : flags[i].
     - If update_mask[i]=0: flags[i] <= base.
     - If update_mask[i]=1 and STICKY_MASK[i]=1: flags[i] <= base | flags_in[i].
     - If update_mask[i]=1 and STICKY_MASK[i]=0: flags[i] <= flags_in[i].
- Push (push=1, pop=0):
  - If depth<STACK_DEPTH: stack[depth] <= current flags (pre-update value); depth <= depth+1.
  - Flags are still updated in the same cycle by load or the update path.
  - If full: no stack change and stack_ovf <= 1; the flag update still proceeds.
- Pop on empty (pop=1, push=0, depth==0): stack_unf <= 1; depth stays 0; the flag update proceeds per priority 2/3.
- push=1 and pop=1 in the same cycle:
  - Both ignored; depth and stack unchanged; stack_ovf <= 1 and stack_unf <= 1 (illegal).
  - The flag update proceeds per priority 2/3.
- err_clear=1: stack_ovf <= 0 and stack_unf <= 0, unless a new error occurs in the same cycle; a new error wins.
- Depth never wraps: it saturates at 0 and at STACK_DEPTH.
- No reset mid-push hazard exists: reset has priority on the same edge and discards the push.

Test Plan (N_FLAGS=4, STACK_DEPTH=4, STICKY_MASK=4'b1000):
- After reset, update_mask=4'b0111, flags_in=4'b1111 -> next cycle flags=4'b0111. Then update_mask=4'b0101, flags_in=4'b0000 -> flags=4'b0010.
- Sticky O: mask=4'b1000 with flags_in=4'b1000, then flags_in=4'b0000 -> flags[3] stays 1. Then clear_sticky=1, mask=0 -> flags[3]=0. Then clear_sticky=1, mask=4'b1000, flags_in=4'b1000 on the same edge -> flags[3]=1.
- Stack fill/drain: load 4'b0001, 4'b0010, 4'b0100, 4'b1000, pushing after each -> depth=4, stack_full=1. A fifth push -> stack_ovf=1, depth=4. Four pops -> flags=4'b1000, 0100, 0010, 0001 in order, stack_empty=1.
- Pop on empty with load_en=1, load_value=4'b1010 -> flags=4'b1010, stack_unf=1, depth=0. Then err_clear -> stack_unf=0.
- Precedence: depth=1 holding 4'b0011, flags=4'b0000; pop=1, load_en=1, load_value=4'b1111 on the same edge -> flags=4'b0011, depth=0.
- Push+pop together at depth=2 -> depth=2, stack unchanged, stack_ovf=stack_unf=1. Then assert reset during a push -> flags=0, depth=0, both errors 0.
